// File: rtl/multdiv_pkg.sv
// Shared definitions for the multdiv sequencer: state encoding, datapath mode codes,
// default sizing and the divide special-case helper.
package multdiv_pkg;

  localparam int WIDTH_DEFAULT = 32;
  localparam int CNT_W_DEFAULT = 6;

  localparam logic MODE_MULT = 1'b0;
  localparam logic MODE_DIV  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Divide by zero, or INT_MIN / -1 whose quotient does not fit in WIDTH bits.
  function automatic logic div_exception(input logic b_zero,
                                         input logic a_min,
                                         input logic b_neg_one);
    return b_zero | (a_min & b_neg_one);
  endfunction

endpackage

// File: rtl/multdiv_step_counter.sv
// Iteration counter for the multdiv sequencer: synchronous clear, count enable,
// wraps to 0 after the terminal index WIDTH-1.
module multdiv_step_counter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] count,
  output logic             terminal
);

  logic [CNT_W-1:0] count_reg;

  assign count    = count_reg;
  assign terminal = (count_reg == CNT_W'(WIDTH - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable) begin
      count_reg <= terminal ? '0 : count_reg + 1'b1;
    end
  end

endmodule

// File: rtl/multdiv_ctrl.sv
// Sequencer for the shared iterative multiply/divide datapath.
// Optional feature: define MULTDIV_EARLY_OUT_EN to finish trivial operations without iterating.
module multdiv_ctrl
  import multdiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic             opA_isZero,
  input  logic             opB_isZero,
  input  logic             opA_isMinInt,
  input  logic             opB_isNegOne,
  input  logic             dp_overflow,
  output logic             dp_load,
  output logic             dp_step,
  output logic             dp_mode,
  output logic             dp_clear_result,
  output logic [CNT_W-1:0] step_count,
  output logic             busy,
  output logic             data_resultRDY,
  output logic             data_exception
);

  state_t state_reg;
  logic   mode_reg;
  logic   div_exc_reg;
  logic   step_reg;
  logic   busy_reg;
  logic   rdy_reg;
  logic   exc_reg;

  logic   start_req;
  logic   start_is_div;
  logic   start_div_exc;
  logic   early_out;
  logic   cnt_terminal;

  assign start_req     = ctrl_MULT | ctrl_DIV;
  assign start_is_div  = ctrl_DIV & ~ctrl_MULT;
  assign start_div_exc = start_is_div & div_exception(opB_isZero, opA_isMinInt, opB_isNegOne);

  // Operands may only be captured when the FSM can accept a new operation.
  assign dp_load = start_req & (state_reg != ST_RUN);

`ifdef MULTDIV_EARLY_OUT_EN
  logic clear_reg;
  assign early_out = start_req &
                     (start_is_div ? start_div_exc : (opA_isZero | opB_isZero));
  assign dp_clear_result = clear_reg;
`else
  logic unused_zero_flag;
  assign unused_zero_flag = opA_isZero;
  assign early_out        = 1'b0;
  assign dp_clear_result  = 1'b0;
`endif

  multdiv_step_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_step_counter (
    .clock    (clock),
    .reset    (reset),
    .clear    (state_reg != ST_RUN),
    .enable   (state_reg == ST_RUN),
    .count    (step_count),
    .terminal (cnt_terminal)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg   <= ST_IDLE;
      mode_reg    <= MODE_MULT;
      div_exc_reg <= 1'b0;
      step_reg    <= 1'b0;
      busy_reg    <= 1'b0;
      rdy_reg     <= 1'b0;
      exc_reg     <= 1'b0;
`ifdef MULTDIV_EARLY_OUT_EN
      clear_reg   <= 1'b0;
`endif
    end else begin
      rdy_reg <= 1'b0;
      exc_reg <= 1'b0;
`ifdef MULTDIV_EARLY_OUT_EN
      clear_reg <= 1'b0;
`endif
      case (state_reg)
        ST_IDLE, ST_DONE: begin
          if (start_req) begin
            mode_reg    <= start_is_div ? MODE_DIV : MODE_MULT;
            div_exc_reg <= start_div_exc;
            if (early_out) begin
              state_reg <= ST_DONE;
              step_reg  <= 1'b0;
              busy_reg  <= 1'b0;
              rdy_reg   <= 1'b1;
              // Only the divide special cases are errors; a zero multiply is a clean 0.
              exc_reg   <= start_is_div;
`ifdef MULTDIV_EARLY_OUT_EN
              clear_reg <= 1'b1;
`endif
            end else begin
              state_reg <= ST_RUN;
              step_reg  <= 1'b1;
              busy_reg  <= 1'b1;
            end
          end else begin
            state_reg <= ST_IDLE;
            step_reg  <= 1'b0;
            busy_reg  <= 1'b0;
          end
        end
        ST_RUN: begin
          if (cnt_terminal) begin
            state_reg <= ST_DONE;
            step_reg  <= 1'b0;
            busy_reg  <= 1'b0;
            rdy_reg   <= 1'b1;
            // Multiply overflow is only valid from the datapath in the final iteration.
            exc_reg   <= (mode_reg == MODE_DIV) ? div_exc_reg : dp_overflow;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          step_reg  <= 1'b0;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign dp_step        = step_reg;
  assign dp_mode        = mode_reg;
  assign busy           = busy_reg;
  assign data_resultRDY = rdy_reg;
  assign data_exception = exc_reg;

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Directed testbench for multdiv_ctrl; honours MULTDIV_EARLY_OUT_EN when defined.
module tb_multdiv_ctrl;

  localparam int WIDTH = 32;
  localparam int CNT_W = 6;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             ctrl_MULT = 1'b0;
  logic             ctrl_DIV = 1'b0;
  logic             opA_isZero = 1'b0;
  logic             opB_isZero = 1'b0;
  logic             opA_isMinInt = 1'b0;
  logic             opB_isNegOne = 1'b0;
  logic             dp_overflow = 1'b0;
  logic             dp_load;
  logic             dp_step;
  logic             dp_mode;
  logic             dp_clear_result;
  logic [CNT_W-1:0] step_count;
  logic             busy;
  logic             data_resultRDY;
  logic             data_exception;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  multdiv_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clock           (clock),
    .reset           (reset),
    .ctrl_MULT       (ctrl_MULT),
    .ctrl_DIV        (ctrl_DIV),
    .opA_isZero      (opA_isZero),
    .opB_isZero      (opB_isZero),
    .opA_isMinInt    (opA_isMinInt),
    .opB_isNegOne    (opB_isNegOne),
    .dp_overflow     (dp_overflow),
    .dp_load         (dp_load),
    .dp_step         (dp_step),
    .dp_mode         (dp_mode),
    .dp_clear_result (dp_clear_result),
    .step_count      (step_count),
    .busy            (busy),
    .data_resultRDY  (data_resultRDY),
    .data_exception  (data_exception)
  );

  // Starts one operation from IDLE and follows it to its resultRDY pulse (or a 60-cycle bound).
  task automatic do_op(input logic m, input logic d, input logic az, input logic bz,
                       input logic amin, input logic bneg, input int ovf_cycle,
                       output int rdy_cycle, output logic exc, output int steps,
                       output logic cnt_ok, output logic clr, output logic load_seen,
                       output logic mode0);
    rdy_cycle = -1; exc = 1'b0; steps = 0; cnt_ok = 1'b1; clr = 1'b0; mode0 = 1'b0;
    @(negedge clock);
    ctrl_MULT = m; ctrl_DIV = d;
    opA_isZero = az; opB_isZero = bz; opA_isMinInt = amin; opB_isNegOne = bneg;
    #1 load_seen = dp_load;
    @(posedge clock); #1;
    ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
    opA_isZero = 1'b0; opB_isZero = 1'b0; opA_isMinInt = 1'b0; opB_isNegOne = 1'b0;
    mode0 = dp_mode;
    for (int k = 0; k < 60; k++) begin
      dp_overflow = (k == ovf_cycle);
      if (dp_step) begin
        steps++;
        if (step_count !== CNT_W'(k)) cnt_ok = 1'b0;
      end
      if (data_resultRDY) begin
        rdy_cycle = k; exc = data_exception; clr = dp_clear_result;
        break;
      end
      @(posedge clock); #1;
    end
    dp_overflow = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic test_reset();
    #2;
    if ({dp_step, dp_mode, dp_clear_result, busy, data_resultRDY, data_exception} !== 6'b0) begin
      $display("FAIL reset_outputs: got %b expected 000000",
               {dp_step, dp_mode, dp_clear_result, busy, data_resultRDY, data_exception});
      n_bad++;
    end
    n_cmp++;
    if (step_count !== '0) begin
      $display("FAIL reset_step_count: got %0d expected 0", step_count); n_bad++;
    end
    n_cmp++;
    @(negedge clock); reset = 1'b0;
    @(posedge clock); #1;
    if (busy !== 1'b0) begin
      $display("FAIL reset_idle_busy: got %b expected 0", busy); n_bad++;
    end
    n_cmp++;
    $display("test_reset done");
  endtask

  task automatic test_mult_basic();
    int r, s; logic e, ok, c, ld, m0;
    do_op(1, 0, 0, 0, 0, 0, -1, r, e, s, ok, c, ld, m0);
    if (ld !== 1'b1) begin $display("FAIL mult_load: got %b expected 1", ld); n_bad++; end
    n_cmp++;
    if (r != 32) begin $display("FAIL mult_rdy_cycle: got %0d expected 32", r); n_bad++; end
    n_cmp++;
    if (s != 32 || ok !== 1'b1) begin
      $display("FAIL mult_steps: got %0d steps cnt_ok=%b expected 32 steps cnt_ok=1", s, ok); n_bad++;
    end
    n_cmp++;
    if (e !== 1'b0) begin $display("FAIL mult_exc: got %b expected 0", e); n_bad++; end
    n_cmp++;
    if (m0 !== 1'b0) begin $display("FAIL mult_mode: got %b expected 0", m0); n_bad++; end
    n_cmp++;
    $display("test_mult_basic: rdy=%0d steps=%0d exc=%b", r, s, e);
  endtask

  task automatic test_div_zero();
    int r, s; logic e, ok, c, ld, m0;
    do_op(0, 1, 0, 1, 0, 0, -1, r, e, s, ok, c, ld, m0);
`ifdef MULTDIV_EARLY_OUT_EN
    if (r != 0 || c !== 1'b1 || s != 0) begin
      $display("FAIL div0_early: got rdy=%0d clr=%b steps=%0d expected rdy=0 clr=1 steps=0", r, c, s); n_bad++;
    end
`else
    if (r != 32 || c !== 1'b0 || s != 32) begin
      $display("FAIL div0_full: got rdy=%0d clr=%b steps=%0d expected rdy=32 clr=0 steps=32", r, c, s); n_bad++;
    end
`endif
    n_cmp++;
    if (e !== 1'b1) begin $display("FAIL div0_exc: got %b expected 1", e); n_bad++; end
    n_cmp++;
    if (m0 !== 1'b1) begin $display("FAIL div0_mode: got %b expected 1", m0); n_bad++; end
    n_cmp++;
    $display("test_div_zero: rdy=%0d exc=%b clr=%b", r, e, c);
  endtask

  task automatic test_div_overflow();
    int r, s; logic e, ok, c, ld, m0;
    do_op(0, 1, 0, 0, 1, 1, -1, r, e, s, ok, c, ld, m0);
    if (e !== 1'b1) begin $display("FAIL divovf_exc: got %b expected 1", e); n_bad++; end
    n_cmp++;
    $display("test_div_overflow minint/-1: rdy=%0d exc=%b", r, e);
    do_op(0, 1, 0, 0, 0, 1, -1, r, e, s, ok, c, ld, m0);
    if (e !== 1'b0 || r != 32) begin
      $display("FAIL divnegone_exc: got exc=%b rdy=%0d expected exc=0 rdy=32", e, r); n_bad++;
    end
    n_cmp++;
    $display("test_div_overflow -1 only: rdy=%0d exc=%b", r, e);
  endtask

  task automatic test_mult_overflow();
    int r, s; logic e, ok, c, ld, m0;
    do_op(1, 0, 0, 0, 0, 0, 31, r, e, s, ok, c, ld, m0);
    if (e !== 1'b1 || r != 32) begin
      $display("FAIL multovf_31: got exc=%b rdy=%0d expected exc=1 rdy=32", e, r); n_bad++;
    end
    n_cmp++;
    $display("test_mult_overflow cycle31: exc=%b", e);
    do_op(1, 0, 0, 0, 0, 0, 10, r, e, s, ok, c, ld, m0);
    if (e !== 1'b0) begin $display("FAIL multovf_10: got %b expected 0", e); n_bad++; end
    n_cmp++;
    $display("test_mult_overflow cycle10: exc=%b", e);
  endtask

  task automatic test_mult_zero();
    int r, s; logic e, ok, c, ld, m0;
    do_op(1, 0, 1, 0, 0, 0, -1, r, e, s, ok, c, ld, m0);
`ifdef MULTDIV_EARLY_OUT_EN
    if (r != 0 || e !== 1'b0 || c !== 1'b1 || s != 0) begin
      $display("FAIL multzero_early: got rdy=%0d exc=%b clr=%b steps=%0d expected 0/0/1/0", r, e, c, s); n_bad++;
    end
`else
    if (r != 32 || e !== 1'b0 || c !== 1'b0) begin
      $display("FAIL multzero_full: got rdy=%0d exc=%b clr=%b expected 32/0/0", r, e, c); n_bad++;
    end
`endif
    n_cmp++;
    $display("test_mult_zero: rdy=%0d exc=%b clr=%b", r, e, c);
  endtask

  task automatic test_back_to_back();
    int first = -1, second = -1;
    @(negedge clock); ctrl_MULT = 1'b1;
    @(posedge clock); #1; ctrl_MULT = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (k == 5) begin
        ctrl_DIV = 1'b1;
        #1;
        if (dp_load !== 1'b0) begin $display("FAIL b2b_run_load: got %b expected 0", dp_load); n_bad++; end
        n_cmp++;
      end
      if (k == 6) begin
        ctrl_DIV = 1'b0;
        if (dp_mode !== 1'b0 || busy !== 1'b1) begin
          $display("FAIL b2b_mode_held: got mode=%b busy=%b expected mode=0 busy=1", dp_mode, busy); n_bad++;
        end
        n_cmp++;
      end
      if (data_resultRDY === 1'b1) begin
        if (first < 0) begin
          first = k;
          ctrl_MULT = 1'b1;
          #1;
          if (dp_load !== 1'b1) begin $display("FAIL b2b_done_load: got %b expected 1", dp_load); n_bad++; end
          n_cmp++;
        end else begin
          second = k;
          break;
        end
      end
      if (first >= 0 && k == first + 1) begin
        if (step_count !== '0 || dp_step !== 1'b1) begin
          $display("FAIL b2b_restart: got step_count=%0d dp_step=%b expected 0/1", step_count, dp_step); n_bad++;
        end
        n_cmp++;
      end
      @(posedge clock); #1;
      ctrl_MULT = 1'b0;
    end
    if (first != 32 || second != 65) begin
      $display("FAIL b2b_rdy_cycles: got first=%0d second=%0d expected 32/65", first, second); n_bad++;
    end
    n_cmp++;
    $display("test_back_to_back: first=%0d second=%0d", first, second);
    @(posedge clock); @(posedge clock); #1;
  endtask

  task automatic test_reset_mid();
    int rdy_seen = 0;
    @(negedge clock); ctrl_MULT = 1'b1;
    @(posedge clock); #1; ctrl_MULT = 1'b0;
    repeat (15) @(posedge clock);
    #1;
    if (step_count !== CNT_W'(15)) begin
      $display("FAIL rstmid_pre_count: got %0d expected 15", step_count); n_bad++;
    end
    n_cmp++;
    reset = 1'b1;
    #1;
    if ({dp_load, dp_step, dp_mode, dp_clear_result, busy, data_resultRDY, data_exception} !== 7'b0
        || step_count !== '0) begin
      $display("FAIL rstmid_outputs: got %b count=%0d expected all 0",
               {dp_load, dp_step, dp_mode, dp_clear_result, busy, data_resultRDY, data_exception}, step_count);
      n_bad++;
    end
    n_cmp++;
    @(negedge clock); reset = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clock); #1;
      if (data_resultRDY === 1'b1) rdy_seen++;
    end
    if (rdy_seen != 0) begin $display("FAIL rstmid_no_rdy: got %0d pulses expected 0", rdy_seen); n_bad++; end
    n_cmp++;
    $display("test_reset_mid: rdy pulses after abort=%0d", rdy_seen);
  endtask

  task automatic test_both_strobes();
    int r, s; logic e, ok, c, ld, m0;
    do_op(1, 1, 0, 0, 0, 0, -1, r, e, s, ok, c, ld, m0);
    if (m0 !== 1'b0 || r != 32) begin
      $display("FAIL both_mode: got mode=%b rdy=%0d expected mode=0 rdy=32", m0, r); n_bad++;
    end
    n_cmp++;
    $display("test_both_strobes: mode=%b rdy=%0d", m0, r);
  endtask

  initial begin
    test_reset();
    test_mult_basic();
    test_div_zero();
    test_div_overflow();
    test_mult_overflow();
    test_mult_zero();
    test_back_to_back();
    test_reset_mid();
    test_both_strobes();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
